// File: rtl/inside_multi_seq_pkg.sv
// inside_pkg: shared widths, defaults and FSM encoding for the multi-jammer range test
package inside_pkg;
    localparam int IN_N = 8;
    localparam int IN_M = 4;
    localparam int IN_STRICT = 0;
    localparam int PT_W = IN_N + 2;
    localparam int R_W = IN_N + 1;
    localparam int JAM_W = 3 * IN_N + 1;
    localparam int D2_W = 2 * IN_N + 7;
    localparam int CNT_W = $clog2(IN_M + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    function automatic int jam_w(int n);
        return 3 * n + 1;
    endfunction
endpackage

// File: rtl/inside_multi_seq_if.sv
// inside_multi_seq_if: request/result bundle between a requester and the sequential range tester
interface inside_multi_seq_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic start;
    logic [2*N+3:0] g_input;
    logic [M*(3*N+1)-1:0] e_input;
    logic busy;
    logic done;
    logic [M-1:0] mask;
    logic [$clog2(M+1)-1:0] count;
    logic in_any;
    logic in_all;
    modport master(output start, g_input, e_input, input busy, done, mask, count, in_any, in_all);
    modport slave(input start, g_input, e_input, output busy, done, mask, count, in_any, in_all);
endinterface

// File: rtl/inside_multi_seq_dist_cmp.sv
// inside_dist_cmp: combinational test of point P against one jammer circle
module inside_dist_cmp #(
    parameter int N = 8,
    parameter int STRICT = 0
) (
    input  logic signed [N+1:0] xp,
    input  logic signed [N+1:0] yp,
    input  logic signed [N-1:0] xj,
    input  logic signed [N-1:0] yj,
    input  logic signed [N:0]   rj,
    output logic                in_range
);
    logic signed [N+2:0] dx, dy;
    logic signed [2*N+6:0] dxe, dye;
    logic signed [2*N+1:0] rje;
    logic [2*N+6:0] d2, r2;
    assign dx = {xp[N+1], xp} - {{3{xj[N-1]}}, xj};
    assign dy = {yp[N+1], yp} - {{3{yj[N-1]}}, yj};
    assign dxe = {{(N+4){dx[N+2]}}, dx};
    assign dye = {{(N+4){dy[N+2]}}, dy};
    assign rje = {{(N+1){rj[N]}}, rj};
    assign d2 = dxe * dxe + dye * dye;
    assign r2 = {5'b0, rje * rje};
    assign in_range = !rj[N] && (STRICT != 0 ? d2 < r2 : d2 <= r2);
endmodule

// File: rtl/inside_multi_seq.sv
// inside_multi_seq: evaluates one latched jammer per cycle and reports mask/count/any/all
module inside_multi_seq
    import inside_pkg::*;
#(
    parameter int N = IN_N,
    parameter int M = IN_M,
    parameter int STRICT = IN_STRICT
) (
    input logic clk,
    input logic rst,
    inside_multi_seq_if.slave bus
);
    localparam int JW = jam_w(N);
    localparam int CW = $clog2(M + 1);
    localparam int IW = M > 1 ? $clog2(M) : 1;
    state_t st, st_nx;
    logic [2*N+3:0] g_q;
    logic [M*JW-1:0] e_q;
    logic [IW-1:0] idx;
    logic [M-1:0] mask_w;
    logic [CW-1:0] cnt_w;
    logic [JW-1:0] jam;
    logic hit, last;
    assign jam = e_q[idx*JW +: JW];
    assign last = idx == IW'(M - 1);
    assign bus.busy = st != IDLE;
    inside_dist_cmp #(.N(N), .STRICT(STRICT)) u_cmp (
        .xp(g_q[2*N+3:N+2]),
        .yp(g_q[N+1:0]),
        .xj(jam[3*N:2*N+1]),
        .yj(jam[2*N:N+1]),
        .rj(jam[N:0]),
        .in_range(hit)
    );
    always_ff @(posedge clk) st <= rst ? IDLE : st_nx;
    always_comb begin
        st_nx = st;
        st_nx = st == IDLE ? (bus.start ? RUN : IDLE) : st == RUN ? (last ? FIN : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            g_q <= '0;
            e_q <= '0;
            idx <= '0;
            mask_w <= '0;
            cnt_w <= '0;
            bus.done <= 1'b0;
            bus.mask <= '0;
            bus.count <= '0;
            bus.in_any <= 1'b0;
            bus.in_all <= 1'b0;
        end else begin
            bus.done <= st == FIN;
            if (st == IDLE && bus.start) begin
                g_q <= bus.g_input;
                e_q <= bus.e_input;
                idx <= '0;
                mask_w <= '0;
                cnt_w <= '0;
            end
            if (st == RUN) begin
                mask_w[idx] <= hit;
                cnt_w <= cnt_w + CW'(hit);
                idx <= last ? '0 : idx + 1'b1;
            end
            if (st == FIN) begin
                bus.mask <= mask_w;
                bus.count <= cnt_w;
                bus.in_any <= |mask_w;
                bus.in_all <= &mask_w;
            end
        end
    end
endmodule

// File: tb/tb_inside_multi_seq.sv
// tb_inside_multi_seq: random and directed requests checked against an integer geometry model
module tb_inside_multi_seq;
    localparam int N = 8;
    localparam int M = 4;
    localparam int JW = 3 * N + 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    inside_multi_seq_if #(.N(N), .M(M)) b0 ();
    inside_multi_seq_if #(.N(N), .M(M)) b1 ();
    assign b1.start = b0.start;
    assign b1.g_input = b0.g_input;
    assign b1.e_input = b0.e_input;
    inside_multi_seq #(.N(N), .M(M), .STRICT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    inside_multi_seq #(.N(N), .M(M), .STRICT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [M-1:0] ref_mask(input logic [2*N+3:0] g, input logic [M*JW-1:0] e, input bit strict);
        int xp, yp, xj, yj, r, d2;
        logic [JW-1:0] j;
        logic [M-1:0] m;
        m = '0;
        xp = int'($signed(g[2*N+3:N+2]));
        yp = int'($signed(g[N+1:0]));
        for (int k = 0; k < M; k++) begin
            j = e[k*JW +: JW];
            xj = int'($signed(j[3*N:2*N+1]));
            yj = int'($signed(j[2*N:N+1]));
            r = int'($signed(j[N:0]));
            d2 = (xp - xj) * (xp - xj) + (yp - yj) * (yp - yj);
            m[k] = r >= 0 && (strict ? d2 < r * r : d2 <= r * r);
        end
        return m;
    endfunction

    function automatic logic [JW-1:0] pj(input int x, input int y, input int r);
        logic [JW-1:0] v;
        v = {x[N-1:0], y[N-1:0], r[N:0]};
        return v;
    endfunction

    function automatic logic [2*N+3:0] pp(input int x, input int y);
        logic [2*N+3:0] v;
        v = {x[N+1:0], y[N+1:0]};
        return v;
    endfunction

    function automatic int rs(input int lo, input int hi);
        return lo + int'($urandom_range(hi - lo));
    endfunction

    function automatic logic [2*N+3:0] rand_g();
        return $urandom_range(1) != 0 ? pp(rs(-8, 8), rs(-8, 8)) : pp(rs(-512, 511), rs(-512, 511));
    endfunction

    function automatic logic [M*JW-1:0] rand_e();
        logic [M*JW-1:0] e;
        for (int k = 0; k < M; k++)
            e[k*JW +: JW] = $urandom_range(3) != 0 ? pj(rs(-6, 6), rs(-6, 6), rs(-2, 9))
                                                   : pj(rs(-128, 127), rs(-128, 127), rs(-256, 255));
        return e;
    endfunction

    task automatic req(input logic [2*N+3:0] g, input logic [M*JW-1:0] e, input bit mid);
        int cyc;
        logic [M-1:0] e0, e1;
        logic [127:0] junk;
        e0 = ref_mask(g, e, 1'b0);
        e1 = ref_mask(g, e, 1'b1);
        b0.g_input = g;
        b0.e_input = e;
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = mid;
        if (mid) begin
            junk = {$urandom, $urandom, $urandom, $urandom};
            b0.e_input = junk[M*JW-1:0];
            b0.g_input = junk[127:128-(2*N+4)];
        end
        check("busy0", b0.busy, 1);
        check("busy1", b1.busy, 1);
        cyc = 0;
        while (!b0.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            b0.start = 1'b0;
        end
        check("latency", cyc, M + 1);
        check("done1", b1.done, 1);
        check("mask0", b0.mask, e0);
        check("count0", b0.count, $countones(e0));
        check("any0", b0.in_any, |e0);
        check("all0", b0.in_all, &e0);
        check("mask1", b1.mask, e1);
        check("count1", b1.count, $countones(e1));
        check("any1", b1.in_any, |e1);
        check("all1", b1.in_all, &e1);
        @(negedge clk);
        check("done_once", b0.done, 0);
        check("idle_after", b0.busy, 0);
    endtask

    initial begin
        int seen;
        b0.start = 1'b0;
        b0.g_input = '0;
        b0.e_input = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", b0.busy, 0);
        check("rst_done", b0.done, 0);
        check("rst_mask", b0.mask, 0);
        check("rst_count", b0.count, 0);
        check("rst_any", b0.in_any, 0);
        check("rst_all", b0.in_all, 0);
        rst = 1'b0;
        @(negedge clk);
        req(pp(0, 0), {pj(0, 0, -1), pj(-2, -2, 3), pj(10, 0, 5), pj(3, 4, 5)}, 1'b0);
        check("t1_mask", b0.mask, 4'b0101);
        check("t1_count", b0.count, 2);
        check("t1_all", b0.in_all, 0);
        check("t2_mask", b1.mask, 4'b0100);
        check("t2_count", b1.count, 1);
        req(pp(-512, 511), {4{pj(127, -128, 255)}}, 1'b0);
        check("t3_mask", b0.mask, 0);
        check("t3_any", b0.in_any, 0);
        req(pp(1, 1), {4{pj(0, 0, 2)}}, 1'b0);
        check("t4_mask", b0.mask, 4'hF);
        check("t4_all", b0.in_all, 1);
        b0.g_input = rand_g();
        b0.e_input = rand_e();
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", b0.busy, 0);
        check("mid_rst_mask", b0.mask, 0);
        check("mid_rst_count", b0.count, 0);
        check("mid_rst_all", b0.in_all, 0);
        seen = 0;
        repeat (M + 3) begin
            @(negedge clk);
            if (b0.done || b1.done) seen++;
        end
        check("mid_rst_no_done", seen, 0);
        req(pp(1, 1), {pj(0, 0, 1), pj(1, 1, 0), pj(3, 3, 2), pj(0, 1, -3)}, 1'b0);
        req(rand_g(), rand_e(), 1'b1);
        req(rand_g(), rand_e(), 1'b0);
        for (int i = 0; i < 30; i++) req(rand_g(), rand_e(), i % 5 == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inside_multi_seq.md
Name: inside_multi_seq

Overview:
Sequential multi-jammer range test for the localization datapath. It latches one point P and a table of M jammers (xJ, yJ, rJ). Over M cycles it evaluates one jammer per cycle and reports a per-jammer inside mask, an inside count, and any/all flags. It generalises the single-jammer inside test: depth M, a selectable boundary mode, and a start/busy/done handshake.

Parameters:
N, 8, jammer coordinate width; point coordinates are N+2 bits signed, radius is N+1 bits signed
M, 4, number of jammers evaluated per request (M >= 1)
STRICT, 0, 0: inside iff d^2 <= r^2 (boundary counts as inside); 1: inside iff d^2 < r^2

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
start  in  1  request pulse; honoured only when busy=0
g_input  in  2N+4  {xP[N+1:0], yP[N+1:0]}, signed two's complement
e_input  in  M*(3N+1)  jammer k occupies bits [(k+1)(3N+1)-1 : k(3N+1)], laid out as {xJ[N-1:0], yJ[N-1:0], rJ[N:0]}, all signed
busy  out  1  high while evaluating
done  out  1  one-cycle pulse when results are valid
mask  out  M  bit k = P inside jammer k
count  out  clog2(M+1)  popcount of mask
in_any  out  1  |mask
in_all  out  1  &mask

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM goes to IDLE.
  - busy=0, done=0, mask=0, count=0, in_any=0, in_all=0.
  - Latched operands are cleared.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 latches g_input and e_input, clears the working mask/count, sets idx=0, goes to RUN, busy=1.
  - RUN: each cycle evaluates jammer idx from the latched copy and writes mask_work[idx]; count_work increments if inside. When idx=M-1 it goes to FIN; otherwise idx+1.
  - FIN: copies the working mask and count to the outputs, computes in_any/in_all, pulses done=1 for one cycle, busy=0, returns to IDLE.
- Latency: start at edge t gives done=1 in cycle t+M+1. Back-to-back requests are possible; start is accepted in the cycle after done.
- start while busy=1: ignored. Inputs changing during RUN have no effect, because the latched copies are used.
- Outputs mask/count/in_any/in_all:
  - Hold their last values until the next FIN; they are not cleared by a new start.
  - Are valid whenever done has been seen since reset.
- Arithmetic per jammer:
  - dx = xP - sext(xJ), dy = yP - sext(yJ), each N+3 bits signed, no overflow.
  - d2 = dx^2 + dy^2, unsigned, 2N+7 bits.
  - r2 = rJ^2, 2N+2 bits, zero-extended for the compare.
  - A jammer with rJ < 0 is never inside, in either mode.
  - rJ = 0: inside only when P == J and STRICT=0.
- Reset mid-RUN discards the request. No done is issued.
- M=1: RUN lasts one cycle, so done comes at t+2.

Decomposition:
- Shared package inside_pkg holds:
  - localparams for point width (N+2), radius width (N+1), jammer record width (3N+1), d2 width (2N+7), count width.
  - FSM state encoding (IDLE/RUN/FIN, 2 bits).
- Sub-module inside_dist_cmp (combinational; params N and STRICT):
  - Inputs: xP, yP, xJ, yJ, rJ. Output: in_range.
  - Instanced once and time-multiplexed by idx. It contains all of the arithmetic above.
- The top level holds the FSM, the idx counter, operand latches, jammer select mux, and the mask/count accumulation.

Test Plan:
1. N=8, M=4, STRICT=0. P=(0,0); jammers (3,4,r=5), (10,0,r=5), (-2,-2,r=3), (0,0,r=-1). Expected: done at start+5, mask=4'b0101, count=2, in_any=1, in_all=0.
2. Same stimulus with STRICT=1. Expected: jammer 0 (d2=25=r2) now outside, so mask=4'b0100, count=1.
3. Extreme widths. P=(-512,511); all jammers (127,-128,r=255). Expected: d2=639^2+639^2=816642 computed without overflow, r2=65025, mask=0, in_all=0, in_any=0.
4. All inside. P=(1,1); four jammers (0,0,r=2). Expected: mask=4'hF, count=4, in_all=1.
5. Handshake sequence:
   - Pulse start again during RUN: it is ignored, done pulses exactly once.
   - Change e_input mid-RUN: no effect on the result.
   - Start again the cycle after done: the second result arrives M+1 cycles later.
6. Assert rst on the 2nd RUN cycle. Expected:
   - Next cycle: busy=0, all outputs 0.
   - No done pulse.
   - A fresh start afterwards completes correctly.
